fetch_stage: RTL and testbench

- Instruction-fetch stage of the RISC-V core; sits directly upstream of the instruction memory.
- Owns the PC and drives the word address into the combinational-read instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect, halt on SYSTEM instructions (ecall/ebreak), and fetch faults.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 39 +++
 rtl/fetch_stage_if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, bubble encoding, fetch FSM states
// and address checks used by the fetch stage.
package riscv_pkg;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0]  OPC_FENCE  = 7'b0001111;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // True when the byte address lies inside a 2^addr_w-word instruction memory.
    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned addr_w);
        return ((pc >> (addr_w + 32'd2)) == 32'd0);
    endfunction

    function automatic logic pc_fetchable(input logic [31:0] pc, input int unsigned addr_w);
        return (pc[1:0] == 2'b00) && pc_in_range(pc, addr_w);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and the
// IF/ID register contents handed to decode.
interface fetch_stage_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              stall_i;
    logic              redirect_i;
    logic [31:0]       redirect_pc_i;
    logic              if_id_valid;
    logic [31:0]       if_id_inst;
    logic [31:0]       if_id_pc;
    logic [31:0]       if_id_pc4;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        output if_id_valid,
        output if_id_inst,
        output if_id_pc,
        output if_id_pc4
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        input  if_id_valid,
        input  if_id_inst,
        input  if_id_pc,
        input  if_id_pc4
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with bubble (flush), load and hold; bubble wins
// over load so a squash is never overridden by a concurrent fetch.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4
);

    // Pipeline register contents; bubbles keep pc/pc4 since they are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= 32'd0;
            pc4   <= 32'd0;
        end else if (bubble) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_in;
            pc    <= pc_in;
            pc4   <= pc4_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and fills IF/ID, handling stall, redirect, SYSTEM halt and faults.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_INST = riscv_pkg::NOP_INST
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.master  bus,
    output logic [31:0]    pc_o,
    output logic           halted,
    output logic           fault,
    output logic [31:0]    fetch_count
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic         load, bubble, count_en;
    logic         redirect_ok;

    assign bus.imem_addr = pc[ADDR_W+1:2];
    assign pc_o          = pc;
    assign redirect_ok   = pc_fetchable(bus.redirect_pc_i, ADDR_W);

    // Next-state, next-PC and IF/ID control; redirect outranks stall and halt.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load      = 1'b0;
        bubble    = 1'b0;
        count_en  = 1'b0;
        case (state)
            RUN: begin
                if (bus.redirect_i) begin
                    bubble = 1'b1;
                    if (redirect_ok) begin
                        pc_nxt = bus.redirect_pc_i;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else if (bus.stall_i) begin
                    state_nxt = RUN;
                end else if (!pc_in_range(pc, ADDR_W)) begin
                    state_nxt = FAULT;
                    bubble    = 1'b1;
                end else begin
                    load     = 1'b1;
                    count_en = 1'b1;
                    pc_nxt   = pc + 32'd4;
                    if (bus.imem_data[6:0] == OPC_SYSTEM) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            HALT: begin
                if (bus.redirect_i) begin
                    bubble = 1'b1;
                    if (redirect_ok) begin
                        pc_nxt    = bus.redirect_pc_i;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else if (bus.stall_i) begin
                    state_nxt = HALT;
                end else begin
                    bubble = 1'b1;
                end
            end
            FAULT: begin
                bubble = 1'b1;
            end
            default: begin
                bubble    = 1'b1;
                state_nxt = FAULT;
            end
        endcase
    end

    // PC, FSM state, fetch counter and the state-decoded status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= 32'd0;
            halted      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_count <= count_en ? fetch_count + 32'd1 : fetch_count;
            halted      <= (state_nxt == HALT);
            fault       <= (state_nxt == FAULT);
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .bubble  (bubble),
        .inst_in (bus.imem_data),
        .pc_in   (pc),
        .pc4_in  (pc + 32'd4),
        .valid   (bus.if_id_valid),
        .inst    (bus.if_id_inst),
        .pc      (bus.if_id_pc),
        .pc4     (bus.if_id_pc4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random stall/redirect
// traffic, checked cycle by cycle against a behavioural fetch model.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int          ADDR_W = 8;
    localparam int          WORDS  = 256;
    localparam logic [31:0] LIMIT  = 32'd1024;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o, fetch_count;
    logic        halted, fault;
    logic [31:0] mem [WORDS];

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.imem_data = mem[bus.imem_addr];

    fetch_stage #(.RESET_PC(32'h0), .ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .pc_o        (pc_o),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic        valid;
        logic [31:0] inst, ipc, ipc4, pc, cnt;
        logic        halted, fault;
    } snap_t;

    snap_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // Reference model: mode 0 = fetching, 1 = halted, 2 = faulted.
    int          m_mode;
    logic        m_valid;
    logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit target_ok(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && (a < LIMIT);
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.valid  = m_valid;
        s.inst   = m_inst;
        s.ipc    = m_ipc;
        s.ipc4   = m_ipc4;
        s.pc     = m_pc;
        s.cnt    = m_cnt;
        s.halted = (m_mode == 1);
        s.fault  = (m_mode == 2);
        return s;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_inst  = NOP;
        m_ipc   = 32'h0;
        m_ipc4  = 32'h0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_inst  = NOP;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc);
        if (m_mode == 2) begin
            model_bubble();
        end else if (rd) begin
            model_bubble();
            if (target_ok(rpc)) begin
                m_pc   = rpc;
                m_mode = 0;
            end else begin
                m_mode = 2;
            end
        end else if (st) begin
            m_cnt = m_cnt;
        end else if (m_mode == 1) begin
            model_bubble();
        end else if (m_pc >= LIMIT) begin
            m_mode = 2;
            model_bubble();
        end else begin
            m_inst  = mem[int'(m_pc / 32'd4)];
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
            if (m_inst[6:0] == OPC_SYSTEM) m_mode = 1;
        end
    endtask

    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        model_step(st, rd, rpc);
        exp_q.push_back(model_snap());
    endtask

    // Asserts reset between edges so the checks prove the reset is asynchronous.
    task automatic do_reset();
        logic [31:0] addr;
        @(negedge clk);
        rst_n             = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        #1;
        addr = 32'(bus.imem_addr);
        check("rst_valid", 32'(bus.if_id_valid), 32'd0);
        check("rst_inst", bus.if_id_inst, NOP);
        check("rst_ifpc", bus.if_id_pc, 32'h0);
        check("rst_ifpc4", bus.if_id_pc4, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        model_reset();
        #2;
        rst_n       = 1'b1;
        bus.stall_i = 1'b1;
        model_step(1'b1, 1'b0, 32'h0);
        exp_q.push_back(model_snap());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == OPC_SYSTEM) w[6:0] = OPC_FENCE;
        return w;
    endfunction

    // Monitor: pops one expected snapshot per active edge and compares all outputs.
    always @(posedge clk) begin
        snap_t e;
        logic [31:0] addr;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            addr = 32'(bus.imem_addr);
            check("if_id_valid", 32'(bus.if_id_valid), 32'(e.valid));
            check("if_id_inst", bus.if_id_inst, e.inst);
            if (e.valid) begin
                check("if_id_pc", bus.if_id_pc, e.ipc);
                check("if_id_pc4", bus.if_id_pc4, e.ipc4);
            end
            check("pc_o", pc_o, e.pc);
            check("imem_addr", addr, (e.pc / 32'd4) % 32'(WORDS));
            check("halted", 32'(halted), 32'(e.halted));
            check("fault", 32'(fault), 32'(e.fault));
            check("fetch_count", fetch_count, e.cnt);
        end
    end

    initial begin
        logic [31:0] word32;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        for (int i = 0; i < WORDS; i++) mem[i] = rand_word();
        mem[0]  = 32'h0000_0013;
        mem[1]  = 32'h0010_0093;
        mem[2]  = 32'h0050_0113;
        mem[76] = EBREAK;
        word32  = mem[32];
        model_reset();
        do_reset();

        // Straight-line fetch with a two-cycle stall after the second fetch
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        settle();
        check("stall_inst", bus.if_id_inst, 32'h0010_0093);
        check("stall_pc", pc_o, 32'h8);
        check("stall_count", fetch_count, 32'd2);
        cycle(1'b0, 1'b0, 32'h0);
        settle();
        check("f3_inst", bus.if_id_inst, 32'h0050_0113);
        check("f3_ifpc", bus.if_id_pc, 32'h8);
        check("f3_ifpc4", bus.if_id_pc4, 32'd12);
        check("f3_pc", pc_o, 32'd12);
        check("f3_count", fetch_count, 32'd3);

        // Redirect beats a simultaneous stall
        cycle(1'b1, 1'b1, 32'h80);
        settle();
        check("redir_valid", 32'(bus.if_id_valid), 32'd0);
        check("redir_pc", pc_o, 32'h80);
        cycle(1'b0, 1'b0, 32'h0);
        settle();
        check("redir_inst", bus.if_id_inst, word32);
        check("redir_ifpc", bus.if_id_pc, 32'h80);

        // ebreak halts, then an older redirect resumes fetch
        cycle(1'b0, 1'b1, 32'h130);
        cycle(1'b0, 1'b0, 32'h0);
        settle();
        check("halt_inst", bus.if_id_inst, EBREAK);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_pc", pc_o, 32'h134);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0);
        settle();
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_pc", pc_o, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);

        // Misaligned and out-of-range targets fault terminally
        cycle(1'b0, 1'b1, 32'h82);
        cycle(1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        settle();
        check("mis_fault", 32'(fault), 32'd1);
        do_reset();
        cycle(1'b0, 1'b1, 32'h400);
        cycle(1'b0, 1'b0, 32'h0);
        settle();
        check("oor_fault", 32'(fault), 32'd1);
        check("oor_valid", 32'(bus.if_id_valid), 32'd0);
        do_reset();

        // Reset taken while halted
        cycle(1'b0, 1'b1, 32'h130);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        do_reset();

        // Random traffic over a memory sprinkled with SYSTEM and FENCE words
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 39))
                0:       mem[i] = EBREAK;
                1:       mem[i] = 32'h0000_0073;
                2, 3:    mem[i] = {$urandom_range(0, 32'h1FF_FFFF), OPC_FENCE};
                default: mem[i] = rand_word();
            endcase
        end
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            int          r;
            if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0)      tgt = $urandom;
                else if (r == 1) tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b10};
                else             tgt = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                cycle($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, tgt);
            end
        end

        settle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
